tag_stream_generator: RTL and testbench
=======================================

Name: tag_stream_generator

Overview:
- Source (master) side of the tag stream: synthesises sorted, multi-lane tag beats in the same lane format the tag consumers receive.
- Emits periodic tags on one programmable channel, optionally alternating rising and falling edges.
- Configured over a Wishbone slave.
- Used as an on-FPGA stimulus source to exercise downstream tag consumers without a Time Tagger attached.

Parameters:
- WORD_WIDTH, 4, number of tag lanes per beat.
- DEFAULT_CHANNEL, 1, channel_select value after reset.

Ports:
- clk  in  1  sole clock. Stream and Wishbone sides are both synchronous to it.
- rst  in  1  synchronous, active-high reset.
- wb_cyc  in  1  Wishbone cycle.
- wb_stb  in  1  Wishbone strobe.
- wb_we  in  1  Wishbone write enable.
- wb_adr  in  8  byte address.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_ack  out  1  acknowledge.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tkeep  out  WORD_WIDTH  per-lane valid.
- m_axis_tagtime  out  64*WORD_WIDTH  lane i at bits [64i+:64].
- m_axis_channel  out  6*WORD_WIDTH  lane i at bits [6i+:6]. Bit 5 = falling edge, bits [4:0] = channel number.

Behaviour:
- Reset values:
  - wb_ack=0, wb_dat_o=0.
  - m_axis_tvalid=0, tkeep=0, tagtime=0, channel=0.
  - Registers: control=0, channel_select=DEFAULT_CHANNEL, period=100, start_time=0, count_limit=0, emitted=0, done=0.
- Register map (32-bit words; 64-bit registers are low word at the lower address):
  - 0: presence, reads 2.
  - 8: control. bit0 enable, bit1 alternate_edges, bit2 done (read-only).
  - 12: channel_select[5:0].
  - 16: period (64 bit).
  - 24: start_time (64 bit).
  - 32: count_limit[31:0]. 0 means unlimited.
  - 36: emitted[31:0], read-only.
  - Unmapped reads return 0; unmapped writes are ignored.
- Wishbone:
  - Every clk with wb_cyc&&wb_stb produces wb_ack=1 on the next cycle. wb_ack is 0 otherwise.
  - wb_dat_o carries read data with the ack and is 0 in all other cycles.
  - Writes to 12/16/20/24/28/32 while enable=1 are acked but ignored.
- Enable and start latency:
  - Writing bit0=1 clears emitted and done, and loads next_time=start_time and edge_phase=0 at the acking edge.
  - First tvalid rises exactly one cycle later.
- Beat generation:
  - The output register advances when !tvalid || tready.
  - Lane i carries tagtime = next_time + i*period (mod 2^64, wrap allowed).
  - Channel field = {edge, channel_select[4:0]}. edge = 0 if alternate_edges=0, otherwise edge = edge_phase XOR (i&1).
  - After each loaded beat: next_time += k*period and emitted += k, where k = number of set tkeep bits. If k is odd and alternate_edges=1, edge_phase toggles.
- Lane packing:
  - tkeep is contiguous from lane 0.
  - Partial beats occur only when the count limit is reached: lanes = min(WORD_WIDTH, count_limit - emitted).
- AXI-Stream rule: while tvalid=1 && tready=0, tvalid, tkeep, tagtime and channel hold stable.
- Termination:
  - When emitted reaches count_limit (nonzero), the final beat completes its handshake.
  - Then tvalid=0, done=1, and enable self-clears.
- Disable mid-stream: a pending beat is held until accepted, then no further beats are produced. emitted reflects only loaded beats.
- period=0 is treated as 1.
- Simultaneous events:
  - A Wishbone write to control on the same cycle as a final beat handshake: the write wins.
  - A re-enable restarts cleanly.
- rst mid-operation: all state returns to reset values on the next edge. Any beat in flight is dropped without a handshake.

Test Plan:
- WORD_WIDTH=4, period=100, start=1000, count=6, alternate=1, channel=1, tready=1 -> beat0 times 1000/1100/1200/1300, tkeep=1111, channels 0x01/0x21/0x01/0x21. beat1 times 1400/1500, tkeep=0011, channels 0x01/0x21. Then tvalid=0, done=1, emitted=6.
- Same setup with tready low for 5 cycles after beat0 is presented -> beat0 held bit-identical for those cycles. beat1 follows the first handshake.
- start=2^64-150, period=100, count=4 -> lane times 2^64-150, 2^64-50, 50, 150 (wrap).
- count=0, enable, run 10 accepting beats, then write enable=0 with tready=0 -> held beat completes once tready=1. Afterwards tvalid stays 0 and emitted=40.
- Write period=500 while enabled -> read of 16 returns 100 and stream spacing stays 100. Read addr 0 -> 2. Read addr 40 -> 0. Each ack is one cycle after stb.
- Assert rst with tvalid=1, tready=0 -> next cycle tvalid=0, control=0, channel_select=1, emitted=0.

Source files
------------

// File: rtl/tag_stream_generator_if.sv
// Bus bundle for the tag stream generator: Wishbone config port plus tag stream.
interface tag_stream_generator_if #(
  parameter int unsigned WORD_WIDTH = 4
);

  // Wishbone configuration port
  logic                      wb_cyc;
  logic                      wb_stb;
  logic                      wb_we;
  logic [7:0]                wb_adr;
  logic [31:0]               wb_dat_i;
  logic [31:0]               wb_dat_o;
  logic                      wb_ack;

  // Multi-lane tag stream
  logic                      m_axis_tvalid;
  logic                      m_axis_tready;
  logic [WORD_WIDTH-1:0]     m_axis_tkeep;
  logic [64*WORD_WIDTH-1:0]  m_axis_tagtime;
  logic [6*WORD_WIDTH-1:0]   m_axis_channel;

  // Generator side: answers Wishbone, sources the stream
  modport master (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i, m_axis_tready,
    output wb_dat_o, wb_ack, m_axis_tvalid, m_axis_tkeep, m_axis_tagtime, m_axis_channel
  );

  // Host / consumer side: issues Wishbone cycles, sinks the stream
  modport slave (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i, m_axis_tready,
    input  wb_dat_o, wb_ack, m_axis_tvalid, m_axis_tkeep, m_axis_tagtime, m_axis_channel
  );

endinterface

// File: rtl/tag_stream_generator.sv
// Periodic tag stream source: emits sorted multi-lane tag beats on one channel,
// configured through a Wishbone register bank.
module tag_stream_generator #(
  parameter int unsigned WORD_WIDTH      = 4,
  parameter logic [5:0]  DEFAULT_CHANNEL = 6'd1
) (
  input  logic                  clk,
  input  logic                  rst,
  tag_stream_generator_if.master bus
);

  localparam int unsigned TIME_W = 64;
  localparam int unsigned CHAN_W = 6;
  localparam int unsigned KEEP_W = $clog2(WORD_WIDTH + 1);

  localparam logic [7:0] ADDR_PRESENCE = 8'd0;
  localparam logic [7:0] ADDR_CONTROL  = 8'd8;
  localparam logic [7:0] ADDR_CHANNEL  = 8'd12;
  localparam logic [7:0] ADDR_PERIOD_L = 8'd16;
  localparam logic [7:0] ADDR_PERIOD_H = 8'd20;
  localparam logic [7:0] ADDR_START_L  = 8'd24;
  localparam logic [7:0] ADDR_START_H  = 8'd28;
  localparam logic [7:0] ADDR_LIMIT    = 8'd32;
  localparam logic [7:0] ADDR_EMITTED  = 8'd36;

  localparam logic [31:0] PRESENCE_ID    = 32'd2;
  localparam logic [63:0] PERIOD_DEFAULT = 64'd100;

  // Configuration and run state
  logic                         enable;
  logic                         alt_edges;
  logic                         done;
  logic [CHAN_W-1:0]            channel_select;
  logic [TIME_W-1:0]            period;
  logic [TIME_W-1:0]            start_time;
  logic [31:0]                  count_limit;
  logic [31:0]                  emitted;
  logic [TIME_W-1:0]            next_time;
  logic                         edge_phase;

  // Registered outputs
  logic                         wb_ack;
  logic [31:0]                  wb_dat_o;
  logic                         tvalid;
  logic [WORD_WIDTH-1:0]        tkeep;
  logic [TIME_W*WORD_WIDTH-1:0] tagtime;
  logic [CHAN_W*WORD_WIDTH-1:0] channel;

  // Combinational helpers
  logic                         wb_req_c;
  logic                         wb_wr_c;
  logic                         wb_rd_c;
  logic                         ctrl_wr_c;
  logic                         cfg_wr_c;
  logic [31:0]                  rd_data_c;
  logic [TIME_W-1:0]            step_c;
  logic [31:0]                  remaining_c;
  logic                         unlimited_c;
  logic                         more_c;
  logic [KEEP_W-1:0]            lanes_c;
  logic [TIME_W-1:0]            lane_time_c [WORD_WIDTH+1];
  logic [TIME_W-1:0]            adv_time_c;
  logic [WORD_WIDTH-1:0]        keep_c;
  logic [TIME_W*WORD_WIDTH-1:0] tagtime_c;
  logic [CHAN_W*WORD_WIDTH-1:0] channel_c;
  logic                         advance_c;
  logic                         load_c;
  logic                         finish_c;

  // Wishbone request decode; config registers are frozen while running
  always_comb begin
    wb_req_c  = bus.wb_cyc && bus.wb_stb;
    wb_wr_c   = wb_req_c && bus.wb_we;
    wb_rd_c   = wb_req_c && !bus.wb_we;
    ctrl_wr_c = wb_wr_c && (bus.wb_adr == ADDR_CONTROL);
    cfg_wr_c  = wb_wr_c && !enable;
  end

  // Register read multiplexer
  always_comb begin
    rd_data_c = 32'd0;
    unique case (bus.wb_adr)
      ADDR_PRESENCE: rd_data_c = PRESENCE_ID;
      ADDR_CONTROL:  rd_data_c = {29'd0, done, alt_edges, enable};
      ADDR_CHANNEL:  rd_data_c = {26'd0, channel_select};
      ADDR_PERIOD_L: rd_data_c = period[31:0];
      ADDR_PERIOD_H: rd_data_c = period[63:32];
      ADDR_START_L:  rd_data_c = start_time[31:0];
      ADDR_START_H:  rd_data_c = start_time[63:32];
      ADDR_LIMIT:    rd_data_c = count_limit;
      ADDR_EMITTED:  rd_data_c = emitted;
      default:       rd_data_c = 32'd0;
    endcase
  end

  // Next beat contents: lane count, per-lane times and channel fields
  always_comb begin
    step_c      = (period == 64'd0) ? 64'd1 : period;
    unlimited_c = (count_limit == 32'd0);
    remaining_c = count_limit - emitted;
    more_c      = unlimited_c || (emitted < count_limit);
    if (unlimited_c || (remaining_c >= 32'(WORD_WIDTH))) begin
      lanes_c = KEEP_W'(WORD_WIDTH);
    end else begin
      lanes_c = KEEP_W'(remaining_c);
    end

    lane_time_c[0] = next_time;
    for (int unsigned i = 1; i <= WORD_WIDTH; i++) begin
      lane_time_c[i] = lane_time_c[i-1] + step_c;
    end

    adv_time_c = next_time;
    for (int unsigned i = 0; i <= WORD_WIDTH; i++) begin
      if (KEEP_W'(i) == lanes_c) begin
        adv_time_c = lane_time_c[i];
      end
    end

    keep_c    = '0;
    tagtime_c = '0;
    channel_c = '0;
    for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
      if (KEEP_W'(i) < lanes_c) begin
        keep_c[i]                      = 1'b1;
        tagtime_c[TIME_W*i +: TIME_W]  = lane_time_c[i];
        channel_c[CHAN_W*i +: CHAN_W]  = {alt_edges & (edge_phase ^ 1'(i)),
                                          channel_select[4:0]};
      end
    end
  end

  // Output register handshake: advance when empty or accepted
  always_comb begin
    advance_c = !tvalid || bus.m_axis_tready;
    load_c    = advance_c && enable && more_c;
    finish_c  = advance_c && enable && !more_c;
  end

  // Wishbone response: single-cycle ack, data only alongside a read ack
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_ack   <= 1'b0;
      wb_dat_o <= 32'd0;
    end else begin
      wb_ack   <= wb_req_c;
      wb_dat_o <= wb_rd_c ? rd_data_c : 32'd0;
    end
  end

  // Static configuration registers, writable only while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      channel_select <= DEFAULT_CHANNEL;
      period         <= PERIOD_DEFAULT;
      start_time     <= 64'd0;
      count_limit    <= 32'd0;
    end else if (cfg_wr_c) begin
      unique case (bus.wb_adr)
        ADDR_CHANNEL:  channel_select     <= bus.wb_dat_i[5:0];
        ADDR_PERIOD_L: period[31:0]       <= bus.wb_dat_i;
        ADDR_PERIOD_H: period[63:32]      <= bus.wb_dat_i;
        ADDR_START_L:  start_time[31:0]   <= bus.wb_dat_i;
        ADDR_START_H:  start_time[63:32]  <= bus.wb_dat_i;
        ADDR_LIMIT:    count_limit        <= bus.wb_dat_i;
        default:       ;
      endcase
    end
  end

  // Run control: beat accounting, termination, and control writes (which take priority)
  always_ff @(posedge clk) begin
    if (rst) begin
      enable     <= 1'b0;
      alt_edges  <= 1'b0;
      done       <= 1'b0;
      emitted    <= 32'd0;
      next_time  <= 64'd0;
      edge_phase <= 1'b0;
    end else begin
      if (load_c) begin
        next_time  <= adv_time_c;
        emitted    <= emitted + 32'(lanes_c);
        edge_phase <= edge_phase ^ (alt_edges & lanes_c[0]);
      end
      if (finish_c) begin
        enable <= 1'b0;
        done   <= 1'b1;
      end
      if (ctrl_wr_c) begin
        enable    <= bus.wb_dat_i[0];
        alt_edges <= bus.wb_dat_i[1];
        if (bus.wb_dat_i[0]) begin
          done       <= 1'b0;
          emitted    <= 32'd0;
          next_time  <= start_time;
          edge_phase <= 1'b0;
        end
      end
    end
  end

  // Stream output register; held stable while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      tvalid  <= 1'b0;
      tkeep   <= '0;
      tagtime <= '0;
      channel <= '0;
    end else if (advance_c) begin
      if (load_c) begin
        tvalid  <= 1'b1;
        tkeep   <= keep_c;
        tagtime <= tagtime_c;
        channel <= channel_c;
      end else begin
        tvalid  <= 1'b0;
        tkeep   <= '0;
        tagtime <= '0;
        channel <= '0;
      end
    end
  end

  assign bus.wb_ack         = wb_ack;
  assign bus.wb_dat_o       = wb_dat_o;
  assign bus.m_axis_tvalid  = tvalid;
  assign bus.m_axis_tkeep   = tkeep;
  assign bus.m_axis_tagtime = tagtime;
  assign bus.m_axis_channel = channel;

endmodule

// File: tb/tb_tag_stream_generator.sv
// Directed bench for tag_stream_generator: stream shape, stalls, wrap, limits, reset.
module tb_tag_stream_generator;

  localparam int unsigned WW = 4;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  tag_stream_generator_if #(.WORD_WIDTH(WW)) bus ();

  tag_stream_generator #(
    .WORD_WIDTH      (WW),
    .DEFAULT_CHANNEL (6'd1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write one register; returns at the negedge where stb is dropped
  task automatic wb_write(input logic [7:0] adr, input logic [31:0] dat);
    bus.wb_cyc   = 1'b1;
    bus.wb_stb   = 1'b1;
    bus.wb_we    = 1'b1;
    bus.wb_adr   = adr;
    bus.wb_dat_i = dat;
    @(negedge clk);
    check($sformatf("wr_ack_%0d", adr), 64'(bus.wb_ack), 64'd1);
    bus.wb_cyc = 1'b0;
    bus.wb_stb = 1'b0;
    bus.wb_we  = 1'b0;
  endtask

  // Read one register and compare; checks the ack drops one cycle later
  task automatic wb_read_check(input string tag, input logic [7:0] adr, input logic [31:0] exp);
    bus.wb_cyc = 1'b1;
    bus.wb_stb = 1'b1;
    bus.wb_we  = 1'b0;
    bus.wb_adr = adr;
    @(negedge clk);
    check({tag, "_ack"}, 64'(bus.wb_ack), 64'd1);
    check(tag, 64'(bus.wb_dat_o), 64'(exp));
    bus.wb_cyc = 1'b0;
    bus.wb_stb = 1'b0;
    @(negedge clk);
    check({tag, "_ack_drop"}, 64'(bus.wb_ack), 64'd0);
    check({tag, "_dat_idle"}, 64'(bus.wb_dat_o), 64'd0);
  endtask

  // Compare the presented beat against hand-given lane parameters
  task automatic check_beat(input string tag, input logic [3:0] keep, input logic [63:0] t0,
                            input logic [63:0] step, input logic [5:0] ch_even,
                            input logic [5:0] ch_odd);
    logic [63:0] exp_t;
    check({tag, "_valid"}, 64'(bus.m_axis_tvalid), 64'd1);
    check({tag, "_keep"}, 64'(bus.m_axis_tkeep), 64'(keep));
    exp_t = t0;
    for (int i = 0; i < int'(WW); i++) begin
      if (keep[i]) begin
        check($sformatf("%s_t%0d", tag, i), bus.m_axis_tagtime[64*i +: 64], exp_t);
        check($sformatf("%s_c%0d", tag, i), 64'(bus.m_axis_channel[6*i +: 6]),
              64'((i % 2 == 0) ? ch_even : ch_odd));
      end
      exp_t = exp_t + step;
    end
  endtask

  initial begin
    logic found;
    tests_run          = 0;
    tests_failed       = 0;
    rst                = 1'b1;
    bus.wb_cyc         = 1'b0;
    bus.wb_stb         = 1'b0;
    bus.wb_we          = 1'b0;
    bus.wb_adr         = 8'd0;
    bus.wb_dat_i       = 32'd0;
    bus.m_axis_tready  = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    check("rst_tkeep", 64'(bus.m_axis_tkeep), 64'd0);
    check("rst_ack", 64'(bus.wb_ack), 64'd0);
    check("rst_dat", 64'(bus.wb_dat_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    wb_read_check("rst_ctrl", 8'd8, 32'd0);
    wb_read_check("rst_chan", 8'd12, 32'd1);
    wb_read_check("rst_period", 8'd16, 32'd100);
    wb_read_check("rst_emitted", 8'd36, 32'd0);

    // Basic run: 6 tags, alternating edges, partial last beat
    wb_write(8'd24, 32'd1000);
    wb_write(8'd28, 32'd0);
    wb_write(8'd32, 32'd6);
    wb_write(8'd8, 32'd3);
    @(negedge clk);
    check_beat("b1_beat0", 4'b1111, 64'd1000, 64'd100, 6'h01, 6'h21);
    @(negedge clk);
    check_beat("b1_beat1", 4'b0011, 64'd1400, 64'd100, 6'h01, 6'h21);
    @(negedge clk);
    check("b1_end_valid", 64'(bus.m_axis_tvalid), 64'd0);
    wb_read_check("b1_ctrl", 8'd8, 32'd6);
    wb_read_check("b1_emitted", 8'd36, 32'd6);

    // Backpressure: beat0 held bit-identical for 5 cycles
    bus.m_axis_tready = 1'b0;
    wb_write(8'd8, 32'd3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_beat($sformatf("stall%0d", c), 4'b1111, 64'd1000, 64'd100, 6'h01, 6'h21);
    end
    bus.m_axis_tready = 1'b1;
    @(negedge clk);
    check_beat("stall_beat1", 4'b0011, 64'd1400, 64'd100, 6'h01, 6'h21);
    @(negedge clk);
    check("stall_end_valid", 64'(bus.m_axis_tvalid), 64'd0);

    // 64-bit wrap of lane times, no edge alternation
    wb_write(8'd24, 32'hFFFF_FF6A);
    wb_write(8'd28, 32'hFFFF_FFFF);
    wb_write(8'd32, 32'd4);
    wb_write(8'd8, 32'd1);
    @(negedge clk);
    check_beat("wrap", 4'b1111, 64'hFFFF_FFFF_FFFF_FF6A, 64'd100, 6'h01, 6'h01);
    check("wrap_lane2", bus.m_axis_tagtime[128 +: 64], 64'd50);
    check("wrap_lane3", bus.m_axis_tagtime[192 +: 64], 64'd150);
    @(negedge clk);
    check("wrap_end_valid", 64'(bus.m_axis_tvalid), 64'd0);
    wb_read_check("wrap_ctrl", 8'd8, 32'd4);

    // period=0 behaves as 1; other channel
    wb_write(8'd16, 32'd0);
    wb_write(8'd24, 32'd5);
    wb_write(8'd28, 32'd0);
    wb_write(8'd32, 32'd3);
    wb_write(8'd12, 32'd5);
    wb_write(8'd8, 32'd1);
    @(negedge clk);
    check_beat("p0", 4'b0111, 64'd5, 64'd1, 6'h05, 6'h05);
    @(negedge clk);
    check("p0_end_valid", 64'(bus.m_axis_tvalid), 64'd0);

    // Unlimited run with frozen config, then disable with a held beat
    wb_write(8'd16, 32'd100);
    wb_write(8'd24, 32'd0);
    wb_write(8'd32, 32'd0);
    wb_write(8'd12, 32'd1);
    bus.m_axis_tready = 1'b0;
    wb_write(8'd8, 32'd1);
    @(negedge clk);
    check_beat("un_beat0", 4'b1111, 64'd0, 64'd100, 6'h01, 6'h01);
    wb_write(8'd16, 32'd500);
    wb_read_check("frozen_period", 8'd16, 32'd100);
    wb_read_check("presence", 8'd0, 32'd2);
    wb_read_check("unmapped", 8'd40, 32'd0);
    check("un_hold_t0", bus.m_axis_tagtime[63:0], 64'd0);
    bus.m_axis_tready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      check($sformatf("spacing%0d", c),
            bus.m_axis_tagtime[127:64] - bus.m_axis_tagtime[63:0], 64'd100);
      if (bus.m_axis_tagtime[63:0] == 64'd3600) found = 1'b1;
    end
    check("beat9_seen", 64'(found), 64'd1);
    bus.m_axis_tready = 1'b0;
    wb_write(8'd8, 32'd0);
    check_beat("held", 4'b1111, 64'd3600, 64'd100, 6'h01, 6'h01);
    bus.m_axis_tready = 1'b1;
    @(negedge clk);
    check("dis_valid0", 64'(bus.m_axis_tvalid), 64'd0);
    repeat (3) @(negedge clk);
    check("dis_valid1", 64'(bus.m_axis_tvalid), 64'd0);
    wb_read_check("dis_emitted", 8'd36, 32'd40);
    wb_read_check("dis_ctrl", 8'd8, 32'd0);

    // Reset while a beat is stalled
    bus.m_axis_tready = 1'b0;
    wb_write(8'd12, 32'd7);
    wb_write(8'd8, 32'd1);
    @(negedge clk);
    check("pre_rst_valid", 64'(bus.m_axis_tvalid), 64'd1);
    check("pre_rst_chan", 64'(bus.m_axis_channel[5:0]), 64'h07);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 64'(bus.m_axis_tvalid), 64'd0);
    check("mid_rst_tagtime", bus.m_axis_tagtime[63:0], 64'd0);
    rst = 1'b0;
    bus.m_axis_tready = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 64'(bus.m_axis_tvalid), 64'd0);
    wb_read_check("post_rst_ctrl", 8'd8, 32'd0);
    wb_read_check("post_rst_chan", 8'd12, 32'd1);
    wb_read_check("post_rst_emitted", 8'd36, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
